// File: rtl/uart_pkg.sv
// uart_pkg: declarations shared by the UART blocks.
//   uart_state_e : receiver/transmitter FSM state encoding
//   DATA_BITS    : number of payload bits per frame
//   majority3    : 2-of-3 vote used to de-noise the sampled line
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: conditions the asynchronous serial line.
//   clk, reset : clock, synchronous active-high reset
//   rx         : raw asynchronous serial input (idles high)
//   maj        : 2-of-3 majority of the last three synchronised samples
//   fall       : one-cycle strobe on a 1->0 transition of the synchronised line
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic maj,
  output logic fall
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [2:0] hist_q,  hist_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    hist_d  = {hist_q[1:0], sync2_q};
  end

  // Everything resets to the idle-line level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign maj  = majority3(hist_q);
  // hist_q[0] is the previous synchronised sample.
  assign fall = hist_q[0] & ~sync2_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry holding register.
//   clk, reset  : clock, synchronous active-high reset
//   rx          : asynchronous serial line, idles high
//   data_out    : received byte, stable while data_valid=1
//   data_valid  : holding register full until data_ack
//   data_ack    : consumer takes data_out
//   busy        : a frame is being received
//   frame_err   : 1-cycle pulse, stop bit sampled low
//   parity_err  : 1-cycle pulse, parity mismatch (constant 0 unless parity build)
//   overrun     : 1-cycle pulse, good frame arrived while holding register full
// Build option: define UART_RX_PARITY_EN to add a parity bit before the stop
// bit; PARITY_ODD then selects odd (1) or even (0) parity.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam logic [9:0] CNT_HALF = 10'(CLKS_PER_BIT / 2 - 1);
  localparam logic [9:0] CNT_FULL = 10'(CLKS_PER_BIT - 1);

  logic maj, fall;

  uart_rx_sampler u_sampler (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .maj   (maj),
    .fall  (fall)
  );

  uart_state_e state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        busy_q, busy_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        stop_par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
  assign stop_par_bad = par_bad_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign stop_par_bad      = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    if (data_ack && data_valid_q) data_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      // Half-bit wait re-centres all later ticks mid-bit; a high sample here is a glitch.
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!maj) begin
            state_d   = DATA;
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shreg_d = {maj, shreg_q[7:1]};
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          par_bad_d = ((^shreg_q) ^ maj) != PARITY_ODD;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!maj) begin
            frame_err_d = 1'b1;
          end else if (stop_par_bad) begin
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b1;
`endif
          end else if (!data_valid_q || data_ack) begin
            data_out_d   = shreg_q;
            data_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
